// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, FSM states and the
// instruction word field layout used by both the encoder and the decode stage.
package instr_encoder_pkg;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_AND   = 8'd2;
  localparam logic [7:0] OP_OR    = 8'd3;
  localparam logic [7:0] OP_ADD   = 8'd4;
  localparam logic [7:0] OP_SUB   = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 24;
  localparam int DEST_HI   = 23;
  localparam int DEST_LO   = 16;
  localparam int SRC1_HI   = 15;
  localparam int SRC1_LO   = 8;
  localparam int SRC2_HI   = 7;
  localparam int SRC2_LO   = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_ENCODE,
    S_WRITE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm;
    logic       last;
  } instr_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: maps one symbolic instruction onto the 32-bit
// [OPCODE][DESTINATION][SOURCE1][SOURCE2] word and flags unknown opcodes.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [2:0]  rd,
  input  logic [2:0]  rs1,
  input  logic [2:0]  rs2,
  input  logic [7:0]  imm,
  output logic [31:0] word,
  output logic        valid
);

  logic [7:0] dest;
  logic [7:0] src1;
  logic [7:0] src2;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    valid = 1'b1;
    dest  = {5'd0, rd};
    src1  = {5'd0, rs1};
    src2  = {5'd0, rs2};
    unique case (opcode)
      OP_LOADI: begin
        src1 = '0;
        src2 = imm;
      end
      OP_MOV:                         src1 = '0;
      OP_AND, OP_OR, OP_ADD, OP_SUB:  ;
      OP_J: begin
        dest = imm;
        src1 = '0;
        src2 = '0;
      end
      OP_BEQ:                         dest = imm;
      default: begin
        valid = 1'b0;
        dest  = '0;
        src1  = '0;
        src2  = '0;
      end
    endcase

    word                     = '0;
    word[OPCODE_HI:OPCODE_LO] = valid ? opcode : 8'd0;
    word[DEST_HI:DEST_LO]     = dest;
    word[SRC1_HI:SRC1_LO]     = src1;
    word[SRC2_HI:SRC2_LO]     = src2;
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: accepts symbolic instructions over a
// valid/ready handshake and writes packed words to sequential memory words.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [7:0]        IN_OPCODE,
  input  logic [2:0]        IN_RD,
  input  logic [2:0]        IN_RS1,
  input  logic [2:0]        IN_RS2,
  input  logic [7:0]        IN_IMM,
  input  logic              IN_LAST,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [31:0]       MEM_WRITEDATA,
  output logic              MEM_WRITE,
  input  logic              MEM_BUSYWAIT,
  output logic [ADDR_W-2:0] INSTR_COUNT,
  output logic [7:0]        ERR_COUNT,
  output logic              ERROR,
  output logic              DONE
);

  localparam logic [ADDR_W-1:0] BASE           = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t      state;
  state_t      state_next;
  instr_t      held;
  logic [31:0] packed_word;
  logic        pack_valid;
  logic        session_start;
  logic        write_done;
  logic        reject;
  logic        at_last_word;
  logic        overflow;

  instr_pack u_pack (
    .opcode (held.opcode),
    .rd     (held.rd),
    .rs1    (held.rs1),
    .rs2    (held.rs2),
    .imm    (held.imm),
    .word   (packed_word),
    .valid  (pack_valid)
  );

  assign session_start = START && (state == S_IDLE || state == S_DONE);
  assign write_done    = (state == S_WRITE) && !MEM_BUSYWAIT;
  assign reject        = (state == S_ENCODE) && !pack_valid;
  assign at_last_word  = (MEM_ADDRESS == LAST_WORD_ADDR);
  assign overflow      = at_last_word && !held.last;

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (START) state_next = S_ACCEPT;
      S_ACCEPT: if (IN_VALID) state_next = S_ENCODE;
      S_ENCODE: begin
        if (pack_valid)     state_next = S_WRITE;
        else if (held.last) state_next = S_DONE;
        else                state_next = S_ACCEPT;
      end
      S_WRITE: begin
        if (!MEM_BUSYWAIT) state_next = (held.last || overflow) ? S_DONE : S_ACCEPT;
      end
      S_DONE:   if (START) state_next = S_ACCEPT;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= S_IDLE;
      IN_READY      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      DONE          <= 1'b0;
      ERROR         <= 1'b0;
      MEM_ADDRESS   <= BASE;
      MEM_WRITEDATA <= '0;
      INSTR_COUNT   <= '0;
      ERR_COUNT     <= '0;
    end else begin
      state     <= state_next;
      IN_READY  <= (state_next == S_ACCEPT);
      MEM_WRITE <= (state_next == S_WRITE);
      DONE      <= (state_next == S_DONE);
      ERROR     <= reject || (write_done && overflow);

      if (state == S_ENCODE && pack_valid) MEM_WRITEDATA <= packed_word;

      if (session_start) begin
        MEM_ADDRESS <= BASE;
        INSTR_COUNT <= '0;
        ERR_COUNT   <= '0;
      end

      if (write_done) begin
        INSTR_COUNT <= INSTR_COUNT + (ADDR_W-1)'(1);
        // The top word is terminal: the address parks there rather than wrapping.
        if (!at_last_word) MEM_ADDRESS <= MEM_ADDRESS + ADDR_W'(4);
      end

      if (reject && ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

  // NOTE: the latched instruction is pure datapath and is only read after
  // ACCEPT has loaded it, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (state == S_ACCEPT && IN_VALID) begin
      held.opcode <= IN_OPCODE;
      held.rd     <= IN_RD;
      held.rs1    <= IN_RS1;
      held.rs2    <= IN_RS2;
      held.imm    <= IN_IMM;
      held.last   <= IN_LAST;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a reference model queues expected writes
// and errors, a monitor pops and compares them as the DUT presents them.
module tb_instr_encoder;

  localparam int AW  = 10;
  localparam int AWS = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic START = 1'b0;
  logic IN_VALID = 1'b0;
  logic IN_LAST = 1'b0;
  logic MEM_BUSYWAIT = 1'b0;
  logic [7:0] IN_OPCODE = '0;
  logic [7:0] IN_IMM = '0;
  logic [2:0] IN_RD = '0;
  logic [2:0] IN_RS1 = '0;
  logic [2:0] IN_RS2 = '0;

  logic          IN_READY, MEM_WRITE, ERROR, DONE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [31:0]   MEM_WRITEDATA;
  logic [AW-2:0] INSTR_COUNT;
  logic [7:0]    ERR_COUNT;

  logic           s_in_ready, s_mem_write, s_error, s_done;
  logic [AWS-1:0] s_mem_address;
  logic [31:0]    s_mem_writedata;
  logic [AWS-2:0] s_instr_count;
  logic [7:0]     s_err_count;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_OPCODE(IN_OPCODE), .IN_RD(IN_RD), .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_IMM(IN_IMM),
    .IN_LAST(IN_LAST), .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_WRITE(MEM_WRITE), .MEM_BUSYWAIT(MEM_BUSYWAIT), .INSTR_COUNT(INSTR_COUNT),
    .ERR_COUNT(ERR_COUNT), .ERROR(ERROR), .DONE(DONE)
  );

  // Small memory twin sharing all inputs, used to reach the address overflow.
  instr_encoder #(.ADDR_W(AWS), .BASE_ADDR(0)) dut_small (
    .CLK(CLK), .RESET(RESET), .START(START), .IN_VALID(IN_VALID), .IN_READY(s_in_ready),
    .IN_OPCODE(IN_OPCODE), .IN_RD(IN_RD), .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_IMM(IN_IMM),
    .IN_LAST(IN_LAST), .MEM_ADDRESS(s_mem_address), .MEM_WRITEDATA(s_mem_writedata),
    .MEM_WRITE(s_mem_write), .MEM_BUSYWAIT(MEM_BUSYWAIT), .INSTR_COUNT(s_instr_count),
    .ERR_COUNT(s_err_count), .ERROR(s_error), .DONE(s_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_err;
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_addr = 0, m_count = 0, m_err = 0;
  bit   m_open = 1'b0;
  int   stall_fixed = 0;
  int   stall_left = 0;
  bit   in_write = 1'b0;
  int   wr_cycles = 0;
  int   last_write_cycles = 0;
  int   s_err_pulses = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1,
                                           input int rs2, input int imm);
    int dst, s1, s2;
    dst = rd; s1 = rs1; s2 = rs2;
    if (op == 0)      begin s1 = 0; s2 = imm; end
    else if (op == 1) s1 = 0;
    else if (op == 6) begin dst = imm; s1 = 0; s2 = 0; end
    else if (op == 7) dst = imm;
    return 32'(op * 16777216 + dst * 65536 + s1 * 256 + s2);
  endfunction

  task automatic model_push(input int op, input int rd, input int rs1, input int rs2,
                            input int imm, input bit last);
    exp_t e;
    if (!m_open) return;
    if (op > 7) begin
      e = '{is_err: 1'b1, addr: m_addr, data: 32'd0};
      sb.push_back(e);
      if (m_err < 255) m_err++;
      if (last) m_open = 1'b0;
    end else begin
      e = '{is_err: 1'b0, addr: m_addr, data: ref_word(op, rd, rs1, rs2, imm)};
      sb.push_back(e);
      m_count++;
      if (m_addr == (1 << AW) - 4) begin
        if (!last) begin
          e = '{is_err: 1'b1, addr: m_addr, data: 32'd0};
          sb.push_back(e);
        end
        m_open = 1'b0;
      end else begin
        m_addr += 4;
        if (last) m_open = 1'b0;
      end
    end
  endtask

  // Memory model: each new write stalls for stall_fixed cycles (random if < 0).
  always @(posedge CLK) begin
    #1;
    if (MEM_WRITE === 1'b1) begin
      if (!in_write) begin
        in_write   = 1'b1;
        stall_left = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 3));
      end else if (stall_left > 0) begin
        stall_left--;
      end
      MEM_BUSYWAIT = (stall_left > 0);
    end else begin
      in_write     = 1'b0;
      MEM_BUSYWAIT = 1'b0;
    end
  end

  // Monitor: every presented write and error pulse is matched against the queue front.
  always @(negedge CLK) begin
    if (MEM_WRITE === 1'b1) begin
      wr_cycles++;
      if (sb.size() == 0 || sb[0].is_err) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=0x%0h data=0x%0h t=%0t", MEM_ADDRESS, MEM_WRITEDATA, $time);
      end else begin
        check("write_addr", 32'(MEM_ADDRESS), 32'(sb[0].addr));
        check("write_data", MEM_WRITEDATA, sb[0].data);
        if (!MEM_BUSYWAIT) begin
          void'(sb.pop_front());
          last_write_cycles = wr_cycles;
        end
      end
    end else begin
      wr_cycles = 0;
    end
    if (ERROR === 1'b1) begin
      if (sb.size() == 0 || !sb[0].is_err) begin
        checks++;
        failures++;
        $display("FAIL unexpected_error addr=0x%0h t=%0t", MEM_ADDRESS, $time);
      end else begin
        void'(sb.pop_front());
      end
    end
    if (s_error === 1'b1) s_err_pulses++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_session();
    START = 1'b1;
    tick();
    START = 1'b0;
    m_addr = 0; m_count = 0; m_err = 0; m_open = 1'b1;
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2,
                      input int imm, input bit last);
    int waited = 0;
    IN_OPCODE = 8'(op); IN_RD = 3'(rd); IN_RS1 = 3'(rs1); IN_RS2 = 3'(rs2);
    IN_IMM = 8'(imm); IN_LAST = last; IN_VALID = 1'b1;
    do begin
      @(negedge CLK);
      waited++;
    end while (IN_READY !== 1'b1 && waited < 50);
    if (IN_READY !== 1'b1) begin
      check("in_ready_timeout", 32'(IN_READY), 32'd1);
      IN_VALID = 1'b0;
      tick();
      return;
    end
    @(posedge CLK);
    model_push(op, rd, rs1, rs2, imm, last);
    #1;
    IN_VALID = 1'b0;
    IN_LAST = 1'(int'($urandom_range(0, 1)));
    IN_OPCODE = 8'($urandom_range(0, 255));
    IN_IMM = 8'($urandom_range(0, 255));
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || MEM_WRITE !== 1'b0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    tick();
  endtask

  task automatic send_random(input int op, input bit last);
    send(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
         int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), last);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  initial begin
    int base_pulses;
    int n;

    repeat (3) tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_in_ready", 32'(IN_READY), 32'd0);
    check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    check("rst_error", 32'(ERROR), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_addr", 32'(MEM_ADDRESS), 32'd0);
    check("rst_wdata", MEM_WRITEDATA, 32'd0);
    check("rst_instr_count", 32'(INSTR_COUNT), 32'd0);
    check("rst_err_count", 32'(ERR_COUNT), 32'd0);
    tick();

    // Session 1: directed instructions from the plan.
    start_session();
    stall_fixed = 0;
    send(0, 4, 0, 0, 8'h05, 1'b0);
    drain();
    check("loadi_write_cycles", 32'(last_write_cycles), 32'd1);
    check("loadi_instr_count", 32'(INSTR_COUNT), 32'd1);

    stall_fixed = 3;
    send(4, 1, 2, 3, 0, 1'b0);
    drain();
    check("add_write_cycles", 32'(last_write_cycles), 32'd4);
    check("add_next_addr", 32'(MEM_ADDRESS), 32'(m_addr));

    stall_fixed = -1;
    send(6, 0, 0, 0, 8'hFE, 1'b0);
    send(7, 0, 1, 2, 8'h02, 1'b0);
    drain();

    send(9, 1, 1, 1, 8'h11, 1'b0);
    drain();
    check("bad_op_err_count", 32'(ERR_COUNT), 32'd1);
    check("bad_op_addr_held", 32'(MEM_ADDRESS), 32'(m_addr));
    send(1, 5, 0, 6, 0, 1'b1);
    drain();
    check("s1_done", 32'(DONE), 32'd1);
    check("s1_instr_count", 32'(INSTR_COUNT), 32'(m_count));

    // Session 2: three instructions, then IN_VALID while DONE must be ignored.
    start_session();
    for (int i = 0; i < 3; i++) send_random(int'($urandom_range(0, 7)), i == 2);
    drain();
    check("s2_done", 32'(DONE), 32'd1);
    check("s2_instr_count", 32'(INSTR_COUNT), 32'd3);
    check("s2_in_ready", 32'(IN_READY), 32'd0);
    IN_VALID = 1'b1;
    IN_OPCODE = 8'd0;
    repeat (5) tick();
    IN_VALID = 1'b0;
    check("done_ignores_valid", 32'(INSTR_COUNT), 32'(m_count));
    check("done_held", 32'(DONE), 32'd1);

    // Session 3: restart clears counters, then random traffic with bad opcodes.
    start_session();
    check("restart_addr", 32'(MEM_ADDRESS), 32'd0);
    check("restart_instr_count", 32'(INSTR_COUNT), 32'd0);
    check("restart_err_count", 32'(ERR_COUNT), 32'd0);
    check("restart_done", 32'(DONE), 32'd0);
    for (int i = 0; i < 40; i++) send_random(int'($urandom_range(0, 10)), i == 39);
    drain();
    check("s3_instr_count", 32'(INSTR_COUNT), 32'(m_count));
    check("s3_err_count", 32'(ERR_COUNT), 32'(m_err));
    check("s3_done", 32'(DONE), 32'd1);

    // Session 4: ERR_COUNT saturation.
    start_session();
    for (int i = 0; i < 260; i++) send(int'($urandom_range(8, 255)), 0, 0, 0, 0, i == 259);
    drain();
    check("sat_err_count", 32'(ERR_COUNT), 32'(m_err));
    check("sat_instr_count", 32'(INSTR_COUNT), 32'd0);

    // Session 5: reset while a write is stalled.
    start_session();
    stall_fixed = 100;
    send(5, 2, 3, 4, 0, 1'b0);
    n = 0;
    while (MEM_WRITE !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("write_started", 32'(MEM_WRITE), 32'd1);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    sb.delete();
    m_open = 1'b0;
    check("midrst_mem_write", 32'(MEM_WRITE), 32'd0);
    check("midrst_in_ready", 32'(IN_READY), 32'd0);
    check("midrst_addr", 32'(MEM_ADDRESS), 32'd0);
    check("midrst_instr_count", 32'(INSTR_COUNT), 32'd0);
    check("midrst_err_count", 32'(ERR_COUNT), 32'd0);
    tick();
    check("idle_in_ready", 32'(IN_READY), 32'd0);

    // Session 6: the small twin overflows on its fourth write.
    stall_fixed = -1;
    base_pulses = s_err_pulses;
    start_session();
    for (int i = 0; i < 4; i++) send_random(int'($urandom_range(0, 7)), 1'b0);
    drain();
    tick();
    check("ovf_err_pulses", 32'(s_err_pulses - base_pulses), 32'd1);
    check("ovf_done", 32'(s_done), 32'd1);
    check("ovf_addr_no_wrap", 32'(s_mem_address), 32'd12);
    check("ovf_instr_count", 32'(s_instr_count), 32'd4);
    check("ovf_err_count", 32'(s_err_count), 32'd0);
    check("big_not_done", 32'(DONE), 32'd0);
    send_random(3, 1'b1);
    drain();
    check("big_done", 32'(DONE), 32'd1);
    check("big_instr_count", 32'(INSTR_COUNT), 32'(m_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
